// File: rtl/grf_pkg.sv
// Shared constants and packed-bus helpers for the GRF family.
package grf_pkg;

   localparam int unsigned GRF_DATA_W = 32;
   localparam int unsigned GRF_ADDR_W = 5;
   localparam int unsigned GRF_CNT_W  = 2;

   // Base bit of port idx within a packed bus of width-sized fields.
   function automatic int unsigned slice_base(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/grf_sb_cnt.sv
// Per-register pending-write counter: saturating up by one, down by up to
// NUM_WR retirements per cycle, with flush and overflow/underflow events.
module grf_sb_cnt
   import grf_pkg::*;
#(
   parameter int unsigned CNT_W = GRF_CNT_W,
   parameter int unsigned DEC_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             inc_i,
   input  logic [DEC_W-1:0] dec_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam int unsigned SW = CNT_W + DEC_W + 1;
   localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

   logic [CNT_W-1:0]     count_q, count_d;
   logic signed [SW-1:0] sum;

   // Next count: flush wins; an overflowing increment is dropped, an
   // underflowing decrement clamps to zero.
   always_comb begin
      count_d = count_q;
      ovf_o   = 1'b0;
      unf_o   = 1'b0;
      sum     = $signed(SW'(count_q)) + $signed(SW'(inc_i)) - $signed(SW'(dec_i));
      if (flush_i) begin
         count_d = '0;
      end else if (en_i) begin
         if (sum > CNT_MAX) begin
            ovf_o   = 1'b1;
            count_d = count_q;
         end else if (sum[SW-1]) begin
            unf_o   = 1'b1;
            count_d = '0;
         end else begin
            count_d = sum[CNT_W-1:0];
         end
      end
   end

   // Counter state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/grf_mp_sb.sv
// Multi-port register file with optional write-to-read bypass and an
// integrated per-register pending-write scoreboard.
module grf_mp_sb
   import grf_pkg::*;
#(
   parameter int unsigned DATA_W   = GRF_DATA_W,
   parameter int unsigned ADDR_W   = GRF_ADDR_W,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1,
   parameter int unsigned CNT_W    = GRF_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_WR-1:0]        wr_retire,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     flush,
   output logic                     sb_overflow,
   output logic                     sb_underflow
);

   localparam int unsigned NREG  = 1 << ADDR_W;
   localparam int unsigned DEC_W = $clog2(NUM_WR + 1);

   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];
   logic [CNT_W-1:0]  cnt   [NREG];
   logic [NREG-1:0]   ovf_evt, unf_evt;
   logic              ovf_q, ovf_d, unf_q, unf_d;

   // Write ports applied in ascending order so the highest index wins.
   always_comb begin : p_wr
      logic [ADDR_W-1:0] wa;
      mem_d = mem_q;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         wa = wr_addr[slice_base(p, ADDR_W) +: ADDR_W];
         if (wr_en[p] && !(ZERO_REG && (wa == '0)))
            mem_d[wa] = wr_data[slice_base(p, DATA_W) +: DATA_W];
      end
   end

   // Register array storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 0; r < NREG; r++) mem_q[r] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar r = 0; r < NREG; r++) begin : g_sb
      logic             inc;
      logic [DEC_W-1:0] dec;

      // Allocation hit and number of retiring writes aimed at this register.
      always_comb begin
         inc = alloc_en && (alloc_addr == ADDR_W'(r));
         dec = '0;
         for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_retire[p] &&
                (wr_addr[slice_base(p, ADDR_W) +: ADDR_W] == ADDR_W'(r)))
               dec = dec + DEC_W'(1);
         end
      end

      grf_sb_cnt #(
         .CNT_W (CNT_W),
         .DEC_W (DEC_W)
      ) u_cnt (
         .clk_i   (clk),
         .rst_ni  (reset),
         .en_i    (!(ZERO_REG && (r == 0))),
         .inc_i   (inc),
         .dec_i   (dec),
         .flush_i (flush),
         .count_o (cnt[r]),
         .ovf_o   (ovf_evt[r]),
         .unf_o   (unf_evt[r])
      );
   end

   // Read ports: zero register, then bypass from the highest matching
   // write port, else stored value; pending drops early on the last retire.
   always_comb begin : p_rd
      logic [ADDR_W-1:0] ra, pa;
      logic [DATA_W-1:0] rv;
      logic [CNT_W-1:0]  cv;
      logic              ret, pend;
      rd_data    = '0;
      rd_pending = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         ra  = rd_addr[slice_base(i, ADDR_W) +: ADDR_W];
         rv  = mem_q[ra];
         cv  = cnt[ra];
         ret = 1'b0;
         for (int unsigned p = 0; p < NUM_WR; p++) begin
            pa = wr_addr[slice_base(p, ADDR_W) +: ADDR_W];
            if (BYPASS && wr_en[p] && (pa == ra))
               rv = wr_data[slice_base(p, DATA_W) +: DATA_W];
            if (wr_en[p] && wr_retire[p] && (pa == ra))
               ret = 1'b1;
         end
         pend = (cv != '0);
         if (BYPASS && (cv == CNT_W'(1)) && ret) pend = 1'b0;
         if (ZERO_REG && (ra == '0)) begin
            rv   = '0;
            pend = 1'b0;
         end
         rd_data[slice_base(i, DATA_W) +: DATA_W] = rv;
         rd_pending[i] = pend;
      end
   end

   assign ovf_d = ovf_q | (|ovf_evt);
   assign unf_d = unf_q | (|unf_evt);

   // Sticky scoreboard error flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign sb_overflow  = ovf_q;
   assign sb_underflow = unf_q;

endmodule

// File: tb/tb_grf_mp_sb.sv
// Directed scoreboard bench for grf_mp_sb with default parameters.
module tb_grf_mp_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_pending;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  wr_retire;
   logic        alloc_en;
   logic [4:0]  alloc_addr;
   logic        flush;
   logic        sb_overflow;
   logic        sb_underflow;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   grf_mp_sb #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_RD   (2),
      .NUM_WR   (2),
      .BYPASS   (1'b1),
      .ZERO_REG (1'b1),
      .CNT_W    (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_pending   (rd_pending),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_retire    (wr_retire),
      .alloc_en     (alloc_en),
      .alloc_addr   (alloc_addr),
      .flush        (flush),
      .sb_overflow  (sb_overflow),
      .sb_underflow (sb_underflow)
   );

   always #5 clk = ~clk;

   task automatic idle();
      wr_en      = '0;
      wr_retire  = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = 1'b0;
      alloc_addr = '0;
      flush      = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic ret);
      wr_en[p]           = 1'b1;
      wr_retire[p]       = ret;
      wr_addr[p*5 +: 5]  = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic alloc(input logic [4:0] a);
      alloc_en   = 1'b1;
      alloc_addr = a;
   endtask

   task automatic rda(input int p, input logic [4:0] a);
      rd_addr[p*5 +: 5] = a;
   endtask

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: observed=%h expected=<queued value>", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // One clock edge, then return at the next falling edge with inputs idle.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   initial begin
      reset   = 1'b0;
      rd_addr = '0;
      idle();
      rda(0, 5);
      #1;
      push("reset_rd", 32'h0);        chk(rd_data[31:0]);
      push("reset_pend", 32'h0);      chk({30'b0, rd_pending});
      push("reset_flags", 32'h0);     chk({30'b0, sb_overflow, sb_underflow});
      @(negedge clk);
      reset = 1'b1;

      // Async reset between edges clears data and pending.
      wr(0, 5, 32'hDEADBEEF, 1'b0);
      alloc(5);
      step();
      #1;
      push("r5_written", 32'hDEADBEEF); chk(rd_data[31:0]);
      push("r5_pending", 32'h1);        chk({31'b0, rd_pending[0]});
      #2 reset = 1'b0;
      #1;
      push("r5_async_clr", 32'h0);      chk(rd_data[31:0]);
      push("r5_pend_clr", 32'h0);       chk({31'b0, rd_pending[0]});
      push("flags_clr", 32'h0);         chk({30'b0, sb_overflow, sb_underflow});
      reset = 1'b1;
      @(negedge clk);
      #1;
      push("r5_after_rst", 32'h0);      chk(rd_data[31:0]);

      // Zero register ignores write, alloc and retire.
      wr(0, 0, 32'hFFFF_FFFF, 1'b1);
      alloc(0);
      rda(0, 0);
      rda(1, 0);
      #1;
      push("r0_bypass", 32'h0);         chk(rd_data[31:0]);
      push("r0_pend", 32'h0);           chk({30'b0, rd_pending});
      step();
      #1;
      push("r0_stored", 32'h0);         chk(rd_data[63:32]);
      push("r0_pend_after", 32'h0);     chk({30'b0, rd_pending});
      push("r0_no_flags", 32'h0);       chk({30'b0, sb_overflow, sb_underflow});

      // Two ports writing r3: port 1 wins, bypassed in the same cycle.
      wr(0, 3, 32'h11, 1'b0);
      wr(1, 3, 32'h22, 1'b0);
      rda(0, 3);
      rda(1, 5);
      #1;
      push("r3_bypass", 32'h22);        chk(rd_data[31:0]);
      push("r5_unaffected", 32'h0);     chk(rd_data[63:32]);
      step();
      #1;
      push("r3_stored", 32'h22);        chk(rd_data[31:0]);

      // r7: saturate at 3, overflow on the 4th alloc, drain with retires.
      rda(0, 7);
      for (int i = 0; i < 3; i++) begin
         alloc(7);
         step();
      end
      #1;
      push("r7_pend3", 32'h1);          chk({31'b0, rd_pending[0]});
      push("ovf_before", 32'h0);        chk({31'b0, sb_overflow});
      alloc(7);
      step();
      #1;
      push("ovf_set", 32'h1);           chk({31'b0, sb_overflow});
      for (int i = 0; i < 3; i++) begin
         wr(0, 7, 32'h70 + i, 1'b1);
         #1;
         push("r7_drain_pend", (i == 2) ? 32'h0 : 32'h1);
         chk({31'b0, rd_pending[0]});
         step();
      end
      #1;
      push("r7_pend_clear", 32'h0);     chk({31'b0, rd_pending[0]});
      push("r7_last_data", 32'h72);     chk(rd_data[31:0]);
      push("unf_not_set", 32'h0);       chk({31'b0, sb_underflow});

      // r9: alloc + retire in the same cycle leaves the count at 1.
      rda(0, 9);
      alloc(9);
      step();
      alloc(9);
      wr(0, 9, 32'h99, 1'b1);
      step();
      #1;
      push("r9_pend_kept", 32'h1);      chk({31'b0, rd_pending[0]});
      wr(0, 9, 32'h9A, 1'b1);
      #1;
      push("r9_last_retire", 32'h0);    chk({31'b0, rd_pending[0]});
      step();
      #1;
      push("unf_before", 32'h0);        chk({31'b0, sb_underflow});
      wr(1, 9, 32'h9B, 1'b1);
      step();
      #1;
      push("unf_set", 32'h1);           chk({31'b0, sb_underflow});
      push("r9_pend_zero", 32'h0);      chk({31'b0, rd_pending[0]});
      push("r9_port1_data", 32'h9B);    chk(rd_data[31:0]);

      // Flush clears counts, ignores alloc/retire, keeps writes and flags.
      rda(0, 2);
      rda(1, 4);
      alloc(2);
      step();
      alloc(2);
      step();
      alloc(4);
      step();
      #1;
      push("pend_r2_r4", 32'h3);        chk({30'b0, rd_pending});
      flush = 1'b1;
      wr(0, 2, 32'h55, 1'b1);
      alloc(4);
      step();
      #1;
      push("flush_pend", 32'h0);        chk({30'b0, rd_pending});
      push("flush_write", 32'h55);      chk(rd_data[31:0]);
      push("flush_flags", 32'h3);       chk({30'b0, sb_overflow, sb_underflow});
      alloc(4);
      step();
      wr(1, 4, 32'h44, 1'b1);
      #1;
      push("r4_count_one", 32'h0);      chk({31'b0, rd_pending[1]});
      push("r4_bypass", 32'h44);        chk(rd_data[63:32]);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
